// File: rtl/mult_pkg.sv
// Shared types and arithmetic helpers for the multiplier result path.
// sat_add works on a fixed wide container so that any accumulator width up to MAX_W-2 can use it.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int PROD_W = 64;
    localparam int MAX_W  = 128;
    localparam int WIDX_W = 7;

    // Inputs are sign-extended to MAX_W by the caller, so the MAX_W sum is exact and
    // bits [width] / [width-1] are the top two bits of the width+1-bit sum.
    // Returns {overflow, result}; result is sign-extended from width bits.
    function automatic logic [MAX_W:0] sat_add(
        input logic [MAX_W-1:0]  acc,
        input logic [MAX_W-1:0]  addend,
        input logic              saturate,
        input logic [WIDX_W-1:0] width
    );
        logic [MAX_W-1:0] one_v;
        logic [MAX_W-1:0] sum_v;
        logic [MAX_W-1:0] max_v;
        logic [MAX_W-1:0] min_v;
        logic [MAX_W-1:0] res_v;
        logic             ovf_v;
        one_v = {{(MAX_W-1){1'b0}}, 1'b1};
        sum_v = acc + addend;
        max_v = (one_v << (width - 7'd1)) - one_v;
        min_v = ~max_v;
        ovf_v = sum_v[width] ^ sum_v[width - 7'd1];
        if (!ovf_v) begin
            res_v = sum_v;
        end else if (saturate) begin
            res_v = sum_v[MAX_W-1] ? min_v : max_v;
        end else if (sum_v[width - 7'd1]) begin
            res_v = sum_v | min_v;
        end else begin
            res_v = sum_v & max_v;
        end
        return {ovf_v, res_v};
    endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product-in / result-out handshake bundle of the product accumulator.
interface product_accumulator_if #(
    parameter int ACC_W   = 72,
    parameter int COUNT_W = 16
);
    import mult_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [PROD_W-1:0]  in_product;
    logic               in_last;
    logic               abort;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_acc;
    logic [COUNT_W-1:0] out_count;
    logic               out_overflow;

    modport master (
        output in_valid, in_product, in_last, abort, out_ready,
        input  in_ready, out_valid, out_acc, out_count, out_overflow
    );

    modport slave (
        input  in_valid, in_product, in_last, abort, out_ready,
        output in_ready, out_valid, out_acc, out_count, out_overflow
    );

endinterface

// File: rtl/acc_sat_adder.sv
// Combinational accumulate step: sign-extend the product, add, detect overflow, clamp or wrap.
// ACC_W must lie in 64..126 so the shared wide adder stays exact.
module acc_sat_adder
    import mult_pkg::*;
#(
    parameter int ACC_W    = 72,
    parameter bit SATURATE = 1'b1
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] product_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              overflow_o
);

    localparam logic [WIDX_W-1:0] ACC_W_IDX = WIDX_W'(ACC_W);

    logic [MAX_W-1:0]       acc_ext_s;
    logic [MAX_W-1:0]       prod_ext_s;
    logic [MAX_W:0]         add_s;
    logic [MAX_W-ACC_W-1:0] add_unused_s;

    assign acc_ext_s  = {{(MAX_W-ACC_W){acc_i[ACC_W-1]}}, acc_i};
    assign prod_ext_s = {{(MAX_W-PROD_W){product_i[PROD_W-1]}}, product_i};
    assign add_s      = sat_add(acc_ext_s, prod_ext_s, SATURATE, ACC_W_IDX);

    // Upper result bits are only a sign extension of sum_o.
    assign overflow_o   = add_s[MAX_W];
    assign sum_o        = add_s[ACC_W-1:0];
    assign add_unused_s = add_s[MAX_W-1:ACC_W];

endmodule

// File: rtl/product_accumulator.sv
// MAC stage behind the signed multiplier: sums products until in_last, then holds the
// closed sum with its term count and sticky overflow until the consumer takes it.
module product_accumulator
    import mult_pkg::*;
#(
    parameter int ACC_W    = 72,
    parameter int COUNT_W  = 16,
    parameter bit SATURATE = 1'b1
) (
    input logic                  clk,
    input logic                  rst_n,
    product_accumulator_if.slave bus
);

    state_e             state_q;
    state_e             state_d;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic               ovf_q;
    logic               ovf_d;
    logic [ACC_W-1:0]   out_acc_q;
    logic [ACC_W-1:0]   out_acc_d;
    logic [COUNT_W-1:0] out_count_q;
    logic [COUNT_W-1:0] out_count_d;
    logic               out_ovf_q;
    logic               out_ovf_d;
    logic               out_valid_q;
    logic               out_valid_d;

    logic               in_ready_s;
    logic               accept_s;
    logic               drain_s;
    logic [COUNT_W-1:0] count_inc_s;
    logic [ACC_W-1:0]   sum_s;
    logic               sum_ovf_s;

    acc_sat_adder #(
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
    ) u_adder (
        .acc_i      (acc_q),
        .product_i  (bus.in_product),
        .sum_o      (sum_s),
        .overflow_o (sum_ovf_s)
    );

    assign in_ready_s  = rst_n & (state_q != HOLD) & ~bus.abort;
    assign accept_s    = bus.in_valid & in_ready_s;
    assign drain_s     = out_valid_q & bus.out_ready;
    assign count_inc_s = (&count_q) ? count_q : (count_q + {{(COUNT_W-1){1'b0}}, 1'b1});

    // Next-state and datapath decode for the IDLE/ACCUM/HOLD sequencer.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        out_acc_d   = out_acc_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE, ACCUM: begin
                // abort blocks in_ready, so it can never coincide with an accept.
                if ((state_q == ACCUM) && bus.abort) begin
                    state_d = IDLE;
                    acc_d   = {ACC_W{1'b0}};
                    count_d = {COUNT_W{1'b0}};
                    ovf_d   = 1'b0;
                end else if (accept_s) begin
                    acc_d   = sum_s;
                    count_d = count_inc_s;
                    ovf_d   = ovf_q | sum_ovf_s;
                    if (bus.in_last) begin
                        state_d     = HOLD;
                        out_acc_d   = sum_s;
                        out_count_d = count_inc_s;
                        out_ovf_d   = ovf_q | sum_ovf_s;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            HOLD: begin
                if (drain_s) begin
                    state_d     = IDLE;
                    acc_d       = {ACC_W{1'b0}};
                    count_d     = {COUNT_W{1'b0}};
                    ovf_d       = 1'b0;
                    out_acc_d   = {ACC_W{1'b0}};
                    out_count_d = {COUNT_W{1'b0}};
                    out_ovf_d   = 1'b0;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d     = IDLE;
                acc_d       = {ACC_W{1'b0}};
                count_d     = {COUNT_W{1'b0}};
                ovf_d       = 1'b0;
                out_acc_d   = {ACC_W{1'b0}};
                out_count_d = {COUNT_W{1'b0}};
                out_ovf_d   = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= {ACC_W{1'b0}};
            count_q     <= {COUNT_W{1'b0}};
            ovf_q       <= 1'b0;
            out_acc_q   <= {ACC_W{1'b0}};
            out_count_q <= {COUNT_W{1'b0}};
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            out_acc_q   <= out_acc_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready     = in_ready_s;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_acc      = out_acc_q;
    assign bus.out_count    = out_count_q;
    assign bus.out_overflow = out_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Drives four accumulator configurations with one shared stream and checks each against
// an integer-arithmetic model, plus directed tables and corner sequences.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_last;
    logic        abort;
    logic        out_ready;
    logic [63:0] in_product;

    always #5 clk = ~clk;

    product_accumulator_if #(.ACC_W(72), .COUNT_W(16)) if0 ();
    product_accumulator_if #(.ACC_W(64), .COUNT_W(16)) if1 ();
    product_accumulator_if #(.ACC_W(64), .COUNT_W(16)) if2 ();
    product_accumulator_if #(.ACC_W(72), .COUNT_W(2))  if3 ();

    assign if0.in_valid = in_valid;  assign if0.in_product = in_product;  assign if0.in_last = in_last;
    assign if0.abort    = abort;     assign if0.out_ready  = out_ready;
    assign if1.in_valid = in_valid;  assign if1.in_product = in_product;  assign if1.in_last = in_last;
    assign if1.abort    = abort;     assign if1.out_ready  = out_ready;
    assign if2.in_valid = in_valid;  assign if2.in_product = in_product;  assign if2.in_last = in_last;
    assign if2.abort    = abort;     assign if2.out_ready  = out_ready;
    assign if3.in_valid = in_valid;  assign if3.in_product = in_product;  assign if3.in_last = in_last;
    assign if3.abort    = abort;     assign if3.out_ready  = out_ready;

    product_accumulator #(.ACC_W(72), .COUNT_W(16), .SATURATE(1'b1)) u_d0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    product_accumulator #(.ACC_W(64), .COUNT_W(16), .SATURATE(1'b1)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    product_accumulator #(.ACC_W(64), .COUNT_W(16), .SATURATE(1'b0)) u_d2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    product_accumulator #(.ACC_W(72), .COUNT_W(2),  .SATURATE(1'b0)) u_d3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    logic signed [127:0] obs_acc [4];
    logic [31:0]         obs_cnt [4];
    logic                obs_v   [4];
    logic                obs_r   [4];
    logic                obs_o   [4];

    assign obs_acc[0] = {{56{if0.out_acc[71]}}, if0.out_acc};
    assign obs_acc[1] = {{64{if1.out_acc[63]}}, if1.out_acc};
    assign obs_acc[2] = {{64{if2.out_acc[63]}}, if2.out_acc};
    assign obs_acc[3] = {{56{if3.out_acc[71]}}, if3.out_acc};
    assign obs_cnt[0] = {16'd0, if0.out_count};
    assign obs_cnt[1] = {16'd0, if1.out_count};
    assign obs_cnt[2] = {16'd0, if2.out_count};
    assign obs_cnt[3] = {30'd0, if3.out_count};
    assign obs_v[0] = if0.out_valid;  assign obs_v[1] = if1.out_valid;
    assign obs_v[2] = if2.out_valid;  assign obs_v[3] = if3.out_valid;
    assign obs_r[0] = if0.in_ready;   assign obs_r[1] = if1.in_ready;
    assign obs_r[2] = if2.in_ready;   assign obs_r[3] = if3.in_ready;
    assign obs_o[0] = if0.out_overflow;  assign obs_o[1] = if1.out_overflow;
    assign obs_o[2] = if2.out_overflow;  assign obs_o[3] = if3.out_overflow;

    function automatic int acc_w(input int k);
        return (k == 1 || k == 2) ? 64 : 72;
    endfunction
    function automatic int cnt_w(input int k);
        return (k == 3) ? 2 : 16;
    endfunction
    function automatic bit sat_en(input int k);
        return (k == 0 || k == 1);
    endfunction

    // Reference model: exact integers, clamped or folded back into range after each add.
    logic signed [127:0] m_acc [4];
    logic signed [127:0] e_acc [4];
    int                  m_cnt [4];
    int                  e_cnt [4];
    logic                m_ovf [4];
    logic                e_ovf [4];
    logic                m_hold;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        logic signed [63:0]  p64;
        logic signed [127:0] s;
        logic signed [127:0] lim;
        int                  cap;
        p64 = in_product;
        if (!rst_n) begin
            m_hold = 1'b0;
            for (int k = 0; k < 4; k++) begin
                m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 1'b0;
                e_acc[k] = 0; e_cnt[k] = 0; e_ovf[k] = 1'b0;
            end
        end else if (m_hold) begin
            if (out_ready) begin
                m_hold = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 1'b0;
                    e_acc[k] = 0; e_cnt[k] = 0; e_ovf[k] = 1'b0;
                end
            end
        end else if (abort) begin
            for (int k = 0; k < 4; k++) begin
                m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 1'b0;
            end
        end else if (in_valid) begin
            for (int k = 0; k < 4; k++) begin
                lim = 128'sd1 <<< (acc_w(k) - 1);
                s   = m_acc[k] + p64;
                if (s > lim - 1 || s < -lim) begin
                    m_ovf[k] = 1'b1;
                    if (sat_en(k))     s = (s > 0) ? lim - 1 : -lim;
                    else if (s > 0)    s = s - (lim <<< 1);
                    else               s = s + (lim <<< 1);
                end
                m_acc[k] = s;
                cap = (1 << cnt_w(k)) - 1;
                if (m_cnt[k] < cap) m_cnt[k]++;
                if (in_last) begin
                    e_acc[k] = m_acc[k]; e_cnt[k] = m_cnt[k]; e_ovf[k] = m_ovf[k];
                    m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 1'b0;
                end
            end
            if (in_last) m_hold = 1'b1;
        end
    endtask

    // One clock: check in_ready with current inputs, cross the edge, check registered outputs.
    task automatic cycle();
        #1;
        for (int k = 0; k < 4; k++)
            check($sformatf("in_ready[%0d]", k), obs_r[k], rst_n && !m_hold && !abort);
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("out_valid[%0d]", k), obs_v[k], m_hold);
            check($sformatf("out_acc[%0d]", k), obs_acc[k], e_acc[k]);
            check($sformatf("out_count[%0d]", k), obs_cnt[k], e_cnt[k]);
            if (m_hold) check($sformatf("out_overflow[%0d]", k), obs_o[k], e_ovf[k]);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] p, input logic l,
                         input logic a, input logic r, input logic n);
        in_valid = v; in_product = p; in_last = l; abort = a; out_ready = r; rst_n = n;
        cycle();
    endtask

    typedef struct {
        logic        v;
        logic [63:0] p;
        logic        l;
        logic        a;
        logic        r;
        logic        n;
        logic        e_ov;
        logic [71:0] e_acc;
        logic [15:0] e_cnt;
    } vec_t;

    localparam logic [71:0] ALL1_72 = 72'hFF_FFFF_FFFF_FFFF_FFFF;

    vec_t tbl [18];

    initial begin
        int t;
        logic [63:0] p;
        tbl[0]  = '{1'b1, 64'd5,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 72'd0,   16'd0};
        tbl[1]  = '{1'b1, -64'sd7,      1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 72'd0,   16'd0};
        tbl[2]  = '{1'b1, 64'd10,       1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 72'd8,   16'd3};
        tbl[3]  = '{1'b0, 64'd0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 72'd0,   16'd0};
        tbl[4]  = '{1'b1, 64'd100,      1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 72'd0,   16'd0};
        tbl[5]  = '{1'b1, 64'd200,      1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 72'd0,   16'd0};
        tbl[6]  = '{1'b1, 64'd999,      1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 72'd0,   16'd0};
        tbl[7]  = '{1'b1, 64'd1,        1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 72'd1,   16'd1};
        tbl[8]  = '{1'b0, 64'd0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 72'd0,   16'd0};
        tbl[9]  = '{1'b1, -64'sd1,      1'b1, 1'b0, 1'b0, 1'b1, 1'b1, ALL1_72, 16'd1};
        for (int i = 10; i < 14; i++)
            tbl[i] = '{1'b1, 64'd55,    1'b1, 1'b0, 1'b0, 1'b1, 1'b1, ALL1_72, 16'd1};
        tbl[14] = '{1'b0, 64'd0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 72'd0,   16'd0};
        tbl[15] = '{1'b1, 64'd42,       1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 72'd42,  16'd1};
        tbl[16] = '{1'b0, 64'd0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 72'd0,   16'd0};
        tbl[17] = '{1'b0, 64'd0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 72'd0,   16'd0};

        drive(1'b1, 64'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_valid", obs_v[0], 1'b0);
        check("reset_acc", obs_acc[0], 128'd0);

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].v, tbl[i].p, tbl[i].l, tbl[i].a, tbl[i].r, tbl[i].n);
            check($sformatf("tbl%0d_valid", i), obs_v[0], tbl[i].e_ov);
            check($sformatf("tbl%0d_acc", i), if0.out_acc, tbl[i].e_acc);
            check($sformatf("tbl%0d_count", i), if0.out_count, tbl[i].e_cnt);
            if (tbl[i].e_ov) check($sformatf("tbl%0d_ovf", i), obs_o[0], 1'b0);
        end

        // Overflow at 64 bits: clamp vs wrap, while the 72-bit sum stays in range.
        drive(1'b1, 64'h4000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 64'h4000_0000_0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
        check("sat64_acc", if1.out_acc, 64'h7FFF_FFFF_FFFF_FFFF);
        check("sat64_ovf", obs_o[1], 1'b1);
        check("wrap64_acc", if2.out_acc, 64'h8000_0000_0000_0000);
        check("wrap64_ovf", obs_o[2], 1'b1);
        check("w72_acc", if0.out_acc, 72'h00_8000_0000_0000_0000);
        check("w72_ovf", obs_o[0], 1'b0);
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        // A later add continues from the clamped value.
        drive(1'b1, 64'h4000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 64'h4000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, -64'sd1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("clamp_keep_acc", if1.out_acc, 64'h7FFF_FFFF_FFFF_FFFE);
        check("clamp_keep_ovf", obs_o[1], 1'b1);
        check("wrap_back_acc", if2.out_acc, 64'h7FFF_FFFF_FFFF_FFFF);
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        drive(1'b1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
        check("minprod_acc", if0.out_acc, 72'hFF_8000_0000_0000_0000);
        check("minprod_ovf", obs_o[0], 1'b0);
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 5; i++)
            drive(1'b1, 64'd1, (i == 4), 1'b0, 1'b0, 1'b1);
        check("cnt2_sat", if3.out_count, 2'd3);
        check("cnt16", if0.out_count, 16'd5);
        check("cnt2_acc", if3.out_acc, 72'd5);
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    t = int'($urandom_range(0, 200)) - 100;
                    p = {{32{t[31]}}, t};
                end
                1: p = $urandom_range(0, 1) ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000;
                default: p = {$urandom, $urandom};
            endcase
            drive($urandom_range(0, 3) != 0, p, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 99) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
